// File: rtl/fb_writer_if.sv
// -----------------------------------------------------------------------------
// fb_writer_if
// Pixel stream carried from the ray-marcher core into the frame-buffer writer.
//   pixel_valid : producer has a pixel this cycle
//   pixel_ready : writer accepts a pixel this cycle
//   pixel_data  : 4-bit grayscale pixel
//   pixel_sof   : first pixel of a frame (qualified by valid && ready)
// Modports: master = pixel producer, slave = frame-buffer writer.
// -----------------------------------------------------------------------------
interface fb_writer_if;
    logic       pixel_valid;
    logic       pixel_ready;
    logic [3:0] pixel_data;
    logic       pixel_sof;

    modport master (output pixel_valid, output pixel_data, output pixel_sof,
                    input  pixel_ready);
    modport slave  (input  pixel_valid, input  pixel_data, input  pixel_sof,
                    output pixel_ready);
endinterface

// File: rtl/fb_writer.sv
// -----------------------------------------------------------------------------
// fb_writer
// Writes a raster-ordered grayscale pixel stream into a double-buffered frame
// buffer. The back buffer is filled, then the buffers swap on the next rising
// edge of display vsync so scan-out never tears.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   enable_in        : permits rendering (looked at only in IDLE and SWAP)
//   pix              : pixel stream (valid/ready/data/sof), slave side
//   vsync_in         : active-high display vsync, same clock domain
//   write_en_out, write_addr_out, write_data_out : BRAM write port;
//                      address is {back-buffer bit, pixel address}
//   front_buf_out    : buffer being displayed (read-address MSB)
//   frame_done_out   : one-cycle pulse at each swap
//   frame_count_out  : number of swaps, wraps at 255
//   sync_err_out     : sticky, SOF arrived at a nonzero position
// -----------------------------------------------------------------------------
module fb_writer #(
    parameter int DISPLAY_WIDTH  = 320,
    parameter int DISPLAY_HEIGHT = 240,
    parameter int ADDR_BITS      = 17
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 enable_in,
    fb_writer_if.slave           pix,
    input  logic                 vsync_in,
    output logic                 write_en_out,
    output logic [ADDR_BITS:0]   write_addr_out,
    output logic [3:0]           write_data_out,
    output logic                 front_buf_out,
    output logic                 frame_done_out,
    output logic [7:0]           frame_count_out,
    output logic                 sync_err_out
);
    localparam int XW = (DISPLAY_WIDTH  > 1) ? $clog2(DISPLAY_WIDTH)  : 1;
    localparam int YW = (DISPLAY_HEIGHT > 1) ? $clog2(DISPLAY_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(DISPLAY_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(DISPLAY_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT_VSYNC, S_SWAP} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  front_q, front_d;
    logic                  we_q, we_d;
    logic [ADDR_BITS:0]    waddr_q, waddr_d;
    logic [3:0]            wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  vsync_q, vsync_prev_q;

    logic                  ready;
    logic                  accept;
    logic                  vsync_rise;
    logic [XW-1:0]         pos_x;
    logic [YW-1:0]         pos_y;
    logic [ADDR_BITS-1:0]  pos_addr;
    logic                  last_beat;

    assign accept     = ready && pix.pixel_valid;
    assign vsync_rise = vsync_q && !vsync_prev_q;

    // An SOF beat forces the raster position back to the origin before it is
    // written, so the pixel lands at address 0 and counting resumes from (1,0).
    assign pos_x    = pix.pixel_sof ? '0 : x_q;
    assign pos_y    = pix.pixel_sof ? '0 : y_q;
    assign pos_addr = pix.pixel_sof ? '0 : addr_q;
    assign last_beat = accept && (pos_x == X_LAST) && (pos_y == Y_LAST);

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (enable_in) state_d = S_WRITE;
            S_WRITE:      if (last_beat) state_d = S_WAIT_VSYNC;
            S_WAIT_VSYNC: if (vsync_rise) state_d = S_SWAP;
            S_SWAP:       state_d = enable_in ? S_WRITE : S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ready = (state_q == S_WRITE);
    end

    // Datapath next values
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        front_d = front_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (accept) begin
            we_d    = 1'b1;
            waddr_d = {~front_q, pos_addr};
            wdata_d = pix.pixel_data;
            if (pix.pixel_sof && ((x_q != '0) || (y_q != '0))) err_d = 1'b1;
            if (pos_x == X_LAST) begin
                x_d = '0;
                y_d = pos_y + 1'b1;
            end else begin
                x_d = pos_x + 1'b1;
                y_d = pos_y;
            end
            addr_d = pos_addr + 1'b1;
        end
        if (state_q == S_SWAP) begin
            front_d = ~front_q;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
        end
    end

    // Datapath registers; write port is one cycle behind the accepted beat
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            front_q      <= 1'b1;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            front_q      <= front_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            vsync_q      <= vsync_in;
            vsync_prev_q <= vsync_q;
        end
    end

    assign pix.pixel_ready  = ready;
    assign write_en_out     = we_q;
    assign write_addr_out   = waddr_q;
    assign write_data_out   = wdata_q;
    assign front_buf_out    = front_q;
    assign frame_done_out   = done_q;
    assign frame_count_out  = cnt_q;
    assign sync_err_out     = err_q;
endmodule

// File: tb/tb_fb_writer.sv
module tb_fb_writer;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          vsync = 1'b0;
    logic          we;
    logic [AB:0]   waddr;
    logic [3:0]    wdata;
    logic          front;
    logic          done;
    logic [7:0]    cnt;
    logic          err;

    int checks   = 0;
    int failures = 0;

    fb_writer_if pif ();

    fb_writer #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .ADDR_BITS(AB)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .enable_in       (enable),
        .pix             (pif.slave),
        .vsync_in        (vsync),
        .write_en_out    (we),
        .write_addr_out  (waddr),
        .write_data_out  (wdata),
        .front_buf_out   (front),
        .frame_done_out  (done),
        .frame_count_out (cnt),
        .sync_err_out    (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [3:0] d, input logic s);
        pif.pixel_valid = 1'b1;
        pif.pixel_data  = d;
        pif.pixel_sof   = s;
        tick();
        pif.pixel_valid = 1'b0;
        pif.pixel_sof   = 1'b0;
    endtask

    // Pulse vsync and wait a bounded number of cycles for the swap pulse.
    task automatic pulse_vsync(output bit seen);
        seen  = 1'b0;
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        checks++;
        if ({pif.pixel_ready, we, waddr, wdata, front, done, cnt, err} !==
            {1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b we=%b a=%h d=%h fr=%b dn=%b c=%0d e=%b want 0,0,0,0,1,0,0,0",
                     pif.pixel_ready, we, waddr, wdata, front, done, cnt, err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (pif.pixel_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b want=1", pif.pixel_ready);
        end
    endtask

    task automatic test_back_to_back(input logic b);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pif.pixel_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got=%b want=1", i, pif.pixel_ready);
            end
            send_pixel(4'(i), 1'b0);
            checks++;
            if ({we, waddr, wdata} !== {1'b1, b, 3'(i), 4'(i)}) begin
                failures++;
                $display("FAIL b2b_write[%0d] got we=%b a=%h d=%h want we=1 a=%h d=%h",
                         i, we, waddr, wdata, {b, 3'(i)}, 4'(i));
            end
        end
        checks++;
        if (pif.pixel_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_drop got=%b want=0", pif.pixel_ready);
        end
        tick();
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_extra_write got=%b want=0", we);
        end
    endtask

    task automatic test_swap;
        bit seen;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({we, done, front} !== 3'b001) begin
                failures++;
                $display("FAIL wait_vsync_idle[%0d] got we=%b dn=%b fr=%b want 0,0,1", i, we, done, front);
            end
        end
        pulse_vsync(seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL swap_seen got=0 want=1");
        end
        checks++;
        if ({front, cnt, pif.pixel_ready} !== {1'b0, 8'd1, 1'b1}) begin
            failures++;
            $display("FAIL swap_state got fr=%b c=%0d rdy=%b want 0,1,1", front, cnt, pif.pixel_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL swap_pulse_width got=%b want=0", done);
        end
        test_back_to_back(1'b1);
    endtask

    task automatic test_valid_gaps;
        bit seen;
        pulse_vsync(seen);
        checks++;
        if (!seen || front !== 1'b1 || cnt !== 8'd2) begin
            failures++;
            $display("FAIL gaps_swap got seen=%b fr=%b c=%0d want 1,1,2", seen, front, cnt);
        end
        for (int i = 0; i < 8; i++) begin
            send_pixel(4'(15 - i), 1'b0);
            checks++;
            if ({we, waddr, wdata} !== {1'b1, 1'b0, 3'(i), 4'(15 - i)}) begin
                failures++;
                $display("FAIL gaps_write[%0d] got we=%b a=%h d=%h want we=1 a=%h d=%h",
                         i, we, waddr, wdata, {1'b0, 3'(i)}, 4'(15 - i));
            end
            if (i < 7) begin
                tick();
                checks++;
                if (we !== 1'b0) begin
                    failures++;
                    $display("FAIL gaps_idle_we[%0d] got=%b want=0", i, we);
                end
            end
        end
        checks++;
        if (pif.pixel_ready !== 1'b0) begin
            failures++;
            $display("FAIL gaps_ready_drop got=%b want=0", pif.pixel_ready);
        end
    endtask

    task automatic test_sof;
        bit seen;
        pulse_vsync(seen);
        checks++;
        if (!seen || front !== 1'b0 || cnt !== 8'd3 || err !== 1'b0) begin
            failures++;
            $display("FAIL sof_swap got seen=%b fr=%b c=%0d e=%b want 1,0,3,0", seen, front, cnt, err);
        end
        for (int i = 0; i < 3; i++) begin
            send_pixel(4'(10 + i), 1'b0);
            checks++;
            if ({we, waddr, wdata} !== {1'b1, 1'b1, 3'(i), 4'(10 + i)}) begin
                failures++;
                $display("FAIL sof_pre[%0d] got we=%b a=%h d=%h", i, we, waddr, wdata);
            end
        end
        send_pixel(4'd9, 1'b1);
        checks++;
        if ({we, waddr, wdata, err} !== {1'b1, 4'b1000, 4'd9, 1'b1}) begin
            failures++;
            $display("FAIL sof_beat got we=%b a=%h d=%h e=%b want we=1 a=8 d=9 e=1", we, waddr, wdata, err);
        end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (pif.pixel_ready !== 1'b1) begin
                failures++;
                $display("FAIL sof_ready[%0d] got=%b want=1", i, pif.pixel_ready);
            end
            send_pixel(4'(i), 1'b0);
            checks++;
            if ({we, waddr} !== {1'b1, 1'b1, 3'(i)}) begin
                failures++;
                $display("FAIL sof_post[%0d] got we=%b a=%h want we=1 a=%h", i, we, waddr, {1'b1, 3'(i)});
            end
        end
        checks++;
        if (pif.pixel_ready !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL sof_end got rdy=%b e=%b want rdy=0 e=1", pif.pixel_ready, err);
        end
    endtask

    task automatic test_async_reset;
        bit seen;
        pulse_vsync(seen);
        checks++;
        if (!seen || front !== 1'b1 || cnt !== 8'd4) begin
            failures++;
            $display("FAIL areset_swap got seen=%b fr=%b c=%0d want 1,1,4", seen, front, cnt);
        end
        for (int i = 0; i < 5; i++) send_pixel(4'(i), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pif.pixel_ready, we, waddr, wdata, front, done, cnt, err} !==
            {1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL areset_clear got rdy=%b we=%b a=%h d=%h fr=%b dn=%b c=%0d e=%b want 0,0,0,0,1,0,0,0",
                     pif.pixel_ready, we, waddr, wdata, front, done, cnt, err);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (pif.pixel_ready !== 1'b1) begin
            failures++;
            $display("FAIL areset_ready got=%b want=1", pif.pixel_ready);
        end
        send_pixel(4'd5, 1'b1);
        checks++;
        if ({we, waddr, wdata, err} !== {1'b1, 4'd0, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL areset_first_sof got we=%b a=%h d=%h e=%b want we=1 a=0 d=5 e=0", we, waddr, wdata, err);
        end
        for (int i = 1; i < 8; i++) begin
            send_pixel(4'(i), 1'b0);
            checks++;
            if ({we, waddr} !== {1'b1, 1'b0, 3'(i)}) begin
                failures++;
                $display("FAIL areset_frame[%0d] got we=%b a=%h want we=1 a=%h", i, we, waddr, {1'b0, 3'(i)});
            end
        end
        checks++;
        if (pif.pixel_ready !== 1'b0) begin
            failures++;
            $display("FAIL areset_frame_end got=%b want=0", pif.pixel_ready);
        end
    endtask

    task automatic test_enable_low;
        bit seen;
        pulse_vsync(seen);
        checks++;
        if (!seen || front !== 1'b0 || cnt !== 8'd1) begin
            failures++;
            $display("FAIL en_swap1 got seen=%b fr=%b c=%0d want 1,0,1", seen, front, cnt);
        end
        tick();
        enable = 1'b0;
        test_back_to_back(1'b1);
        pulse_vsync(seen);
        checks++;
        if (!seen || front !== 1'b1 || cnt !== 8'd2 || pif.pixel_ready !== 1'b0) begin
            failures++;
            $display("FAIL en_swap2 got seen=%b fr=%b c=%0d rdy=%b want 1,1,2,0", seen, front, cnt, pif.pixel_ready);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (pif.pixel_ready !== 1'b0) begin
                failures++;
                $display("FAIL en_idle_ready[%0d] got=%b want=0", i, pif.pixel_ready);
            end
        end
        enable = 1'b1;
        tick();
        checks++;
        if (pif.pixel_ready !== 1'b1) begin
            failures++;
            $display("FAIL en_resume_ready got=%b want=1", pif.pixel_ready);
        end
    endtask

    initial begin
        pif.pixel_valid = 1'b0;
        pif.pixel_data  = 4'd0;
        pif.pixel_sof   = 1'b0;
        test_reset();
        test_back_to_back(1'b0);
        test_swap();
        test_valid_gaps();
        test_sof();
        test_async_reset();
        test_enable_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
